dmem_arbiter: RTL

Two-port arbiter and sequencer for the single-port data memory. It sits between two requesters and the memory's `address`/`write_data`/`mem_write`/`read_data` port. Port 0 is the core load/store unit; port 1 is the debug/loader port. It grants one access at a time with round-robin fairness, range-checks addresses against the memory depth, and returns registered read data with a response strobe.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, port index constants and default geometry.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin winner select.
// A lone requester always wins; on a tie the port that did not win last time wins.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port data memory: round-robin grant,
// one registered command per two cycles, range check and registered response strobe.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rerr,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rerr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  // One extra bit keeps the compare exact even when MEM_DEPTH equals 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic              last_grant_q;
  logic [1:0]        grant;
  logic              accept;

  logic              cmd_port_q;
  logic              cmd_we_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              in_range;

  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rerr_q;

  rr_arb2 u_rr_arb2 (
    .valid0     (m0_valid),
    .valid1     (m1_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign accept   = (state_q == IDLE) && (grant != 2'b00);
  assign m0_ready = (state_q == IDLE) && grant[0];
  assign m1_ready = (state_q == IDLE) && grant[1];
  assign in_range = {1'b0, cmd_addr_q} < DEPTH_EXT;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_DBG;
      cmd_port_q   <= PORT_CORE;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rvalid_q     <= 2'b00;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
    end else begin
      rvalid_q <= 2'b00;
      if (accept) begin
        cmd_port_q   <= grant[1];
        cmd_we_q     <= grant[1] ? m1_we    : m0_we;
        cmd_addr_q   <= grant[1] ? m1_addr  : m0_addr;
        cmd_wdata_q  <= grant[1] ? m1_wdata : m0_wdata;
        last_grant_q <= grant[1];
      end
      // The read happens in the same cycle as any write, so writes return the old word.
      if (state_q == ACCESS) begin
        rvalid_q[cmd_port_q] <= 1'b1;
        rdata_q              <= in_range ? mem_read_data : '0;
        rerr_q               <= !in_range;
      end
    end
  end

  // The write enable is gated by rst so a reset edge never commits a write.
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    if (state_q == ACCESS && in_range) begin
      mem_address    = cmd_addr_q;
      mem_write_data = cmd_wdata_q;
      mem_write      = cmd_we_q && !rst;
    end
  end

  assign m0_rvalid = rvalid_q[PORT_CORE];
  assign m1_rvalid = rvalid_q[PORT_DBG];
  assign m0_rdata  = m0_rvalid ? rdata_q : '0;
  assign m1_rdata  = m1_rvalid ? rdata_q : '0;
  assign m0_rerr   = m0_rvalid && rerr_q;
  assign m1_rerr   = m1_rvalid && rerr_q;

endmodule
